// File: rtl/interp_stream_feeder.sv
// interp_stream_feeder: FIFO-buffered valid/ready wrapper around a combinational LUT interpolator.
// The FIFO head feeds interp_x; interp_y is captured into a stallable output register.
module interp_stream_feeder #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] interp_x,
    input  logic [DATA_W-1:0] interp_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PTR_W:0]    fifo_count,
    output logic [CNT_W-1:0]  sample_count
);
    localparam logic [PTR_W:0]   FULL    = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   OCC_ONE = 1;
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0] SMP_ONE = 1;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr, r_rd;
    logic [PTR_W:0]    r_cnt;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [CNT_W-1:0]  r_samples;
    logic              w_push, w_load, w_deliver;

    // No pass-through at full: in_ready ignores a same-cycle pop.
    assign in_ready     = (r_cnt < FULL) && !flush;
    assign w_push       = in_valid && in_ready;
    assign w_load       = (r_cnt != '0) && (!r_out_valid || out_ready);
    assign w_deliver    = r_out_valid && out_ready;
    assign interp_x     = (r_cnt != '0) ? r_mem[r_rd] : '0;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign fifo_count   = r_cnt;
    assign sample_count = r_samples;

    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr] <= in_data;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_wr        <= '0;
            r_rd        <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (flush) begin
            r_wr        <= '0;
            r_rd        <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + PTR_ONE;
            if (w_load) begin
                r_rd        <= r_rd + PTR_ONE;
                r_out_data  <= interp_y;
                r_out_valid <= 1'b1;
            end else if (w_deliver) r_out_valid <= 1'b0;
            r_cnt <= (w_push && !w_load) ? r_cnt + OCC_ONE :
                     (!w_push && w_load) ? r_cnt - OCC_ONE : r_cnt;
        end

    // Delivered-sample counter survives flush; only rst clears it.
    always_ff @(posedge clk or posedge rst)
        if (rst) r_samples <= '0;
        else if (w_deliver) r_samples <= r_samples + SMP_ONE;
endmodule
